lcd_cmd_seq: RTL and testbench

Upstream command sequencer for the LCD image controller.
- Holds a small host-loaded script of 3-bit image commands.
- On start, issues the commands one at a time over the controller's cmd/cmd_valid/busy handshake.
- Ends with a write command (code 0) and waits for the controller's done.
- Replaces manual host pacing of commands; reports progress and completion to the host.

---
 rtl/lcd_cmd_seq_if.sv | 22 ++
 rtl/lcd_cmd_seq.sv | 150 +++++++++++++++
 tb/tb_lcd_cmd_seq.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_cmd_seq_if.sv
// Command handshake between the sequencer and the LCD image controller.
// The sequencer drives cmd/cmd_valid; the controller answers with busy/done.
interface lcd_cmd_seq_if;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic       busy;
    logic       done;

    modport master (
        output cmd,
        output cmd_valid,
        input  busy,
        input  done
    );

    modport slave (
        input  cmd,
        input  cmd_valid,
        output busy,
        output done
    );
endinterface

// File: rtl/lcd_cmd_seq.sv
// Script-driven command sequencer for the LCD image controller.
// The host loads a short list of 3-bit command codes, pulses start, and the
// sequencer paces them out over the controller handshake until a write (0)
// has been issued and the controller reports done.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | no run in progress; script may be written, start is accepted
// WAIT_READY | next command pending; issued once busy is sampled low
// WAIT_ACK   | command strobed; waiting for busy to rise or the ack timeout
// WAIT_DONE  | write issued; waiting for the controller's done
module lcd_cmd_seq #(
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int ACK_TO = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [2:0]    prog_data,
    lcd_cmd_seq_if.master ctrl,
    output logic          seq_busy,
    output logic          seq_done,
    output logic [4:0]    cmd_count
);

    // The ack timer counts down from ACK_TO-1; expiry is the terminal count 0.
    localparam int TW = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;
    localparam logic [TW-1:0] ACK_LAST = TW'(ACK_TO - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_READY = 2'd1,
        WAIT_ACK   = 2'd2,
        WAIT_DONE  = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [AW:0]   ptr, ptr_nxt;
    logic [2:0]    cmd_q, cmd_nxt;
    logic          cmd_valid_q, cmd_valid_nxt;
    logic          seq_busy_q, seq_busy_nxt;
    logic          seq_done_q, seq_done_nxt;
    logic [4:0]    count_q, count_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [2:0]    fetch;

    logic [2:0]    mem [DEPTH];

    // Script storage: host writes only land while no run is in progress; no reset.
    always_ff @(posedge clk) begin
        if (prog_we && !seq_busy_q) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // Running past the last entry without meeting a write forces an implicit write.
    assign fetch = ptr[AW] ? 3'd0 : mem[ptr[AW-1:0]];

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            cmd_q       <= 3'd0;
            cmd_valid_q <= 1'b0;
            seq_busy_q  <= 1'b0;
            seq_done_q  <= 1'b0;
            count_q     <= 5'd0;
            timer       <= '0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            cmd_q       <= cmd_nxt;
            cmd_valid_q <= cmd_valid_nxt;
            seq_busy_q  <= seq_busy_nxt;
            seq_done_q  <= seq_done_nxt;
            count_q     <= count_nxt;
            timer       <= timer_nxt;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        cmd_nxt       = cmd_q;
        cmd_valid_nxt = 1'b0;
        seq_busy_nxt  = seq_busy_q;
        seq_done_nxt  = seq_done_q;
        count_nxt     = count_q;
        timer_nxt     = timer;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt    = WAIT_READY;
                    seq_busy_nxt = 1'b1;
                    seq_done_nxt = 1'b0;
                    ptr_nxt      = '0;
                    count_nxt    = 5'd0;
                end
            end

            WAIT_READY: begin
                if (!ctrl.busy) begin
                    state_nxt     = WAIT_ACK;
                    cmd_nxt       = fetch;
                    cmd_valid_nxt = 1'b1;
                    count_nxt     = (count_q == 5'd31) ? count_q : count_q + 5'd1;
                    timer_nxt     = ACK_LAST;
                end
            end

            WAIT_ACK: begin
                if (ctrl.busy || (timer == '0)) begin
                    if (cmd_q == 3'd0) begin
                        state_nxt = WAIT_DONE;
                    end else begin
                        state_nxt = WAIT_READY;
                        ptr_nxt   = ptr + {{AW{1'b0}}, 1'b1};
                    end
                end else begin
                    timer_nxt = timer - TW'(1);
                end
            end

            WAIT_DONE: begin
                if (ctrl.done) begin
                    state_nxt    = IDLE;
                    seq_busy_nxt = 1'b0;
                    seq_done_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign ctrl.cmd       = cmd_q;
    assign ctrl.cmd_valid = cmd_valid_q;
    assign seq_busy       = seq_busy_q;
    assign seq_done       = seq_done_q;
    assign cmd_count      = count_q;

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Bench for lcd_cmd_seq: directed steps, a small controller model, and a
// scoreboard queue of expected command codes popped on every strobe.
module tb_lcd_cmd_seq;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int ACK_TO = 8;

    logic          clk;
    logic          reset;
    logic          start;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [2:0]    prog_data;
    logic          seq_busy;
    logic          seq_done;
    logic [4:0]    cmd_count;

    lcd_cmd_seq_if ctrl();

    lcd_cmd_seq #(.DEPTH(DEPTH), .AW(AW), .ACK_TO(ACK_TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .ctrl      (ctrl.master),
        .seq_busy  (seq_busy),
        .seq_done  (seq_done),
        .cmd_count (cmd_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         errors = 0;
    int         checks = 0;
    logic [2:0] sb[$];
    int         cyc = 0;
    int         ctrl_mode = 0;   // 0: busy pulse model, 1: never busy, 2: bench-driven
    int         pend = 0;
    int         bcnt = 0;
    bit         last_was_write = 0;
    bit         strobe_now = 0;
    bit         prev_valid = 0;
    int         strobes = 0;
    int         last_strobe_cyc = 0;
    bit         gap_armed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs 1 unit after the edge, score strobes, step the controller model.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        strobe_now = (ctrl.cmd_valid === 1'b1);
        if (strobe_now) begin
            strobes++;
            chk("strobe_width", {31'd0, prev_valid}, 32'd0);
            chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) chk("cmd_order", {29'd0, ctrl.cmd}, {29'd0, sb.pop_front()});
            if (ctrl_mode == 1 && gap_armed) chk("ack_gap", cyc - last_strobe_cyc, ACK_TO + 1);
            last_strobe_cyc = cyc;
            gap_armed       = 1;
            last_was_write  = (ctrl.cmd == 3'd0);
        end
        prev_valid = (ctrl.cmd_valid === 1'b1);
        ctrl.done = 1'b0;
        if (ctrl_mode == 0) begin
            if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) begin
                    ctrl.busy = 1'b0;
                    if (last_was_write) ctrl.done = 1'b1;
                end
            end
            if (pend != 0) begin
                ctrl.busy = 1'b1;
                bcnt      = 3;
                pend      = 0;
            end
            if (strobe_now) pend = 1;
        end
    endtask

    task automatic prog(input int addr, input int data);
        prog_we   = 1'b1;
        prog_addr = AW'(addr);
        prog_data = 3'(data);
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic run_start();
        strobes   = 0;
        gap_armed = 0;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_seq_done(input int budget, input string tag);
        int n = 0;
        while (seq_done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_done_in_time"}, {31'd0, seq_done}, 32'd1);
    endtask

    task automatic push3(input int a, input int b, input int c);
        sb.push_back(3'(a));
        sb.push_back(3'(b));
        sb.push_back(3'(c));
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        start     = 1'b0;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = 3'd0;
        ctrl.busy = 1'b0;
        ctrl.done = 1'b0;
        tick();
        tick();
        chk("rst_cmd", {29'd0, ctrl.cmd}, 32'd0);
        chk("rst_cmd_valid", {31'd0, ctrl.cmd_valid}, 32'd0);
        chk("rst_seq_busy", {31'd0, seq_busy}, 32'd0);
        chk("rst_seq_done", {31'd0, seq_done}, 32'd0);
        chk("rst_cmd_count", {27'd0, cmd_count}, 32'd0);
        reset = 1'b0;

        // Script [3,1,6,0] with the busy-pulse controller
        prog(0, 3); prog(1, 1); prog(2, 6); prog(3, 0);
        sb.push_back(3'd3);
        push3(1, 6, 0);
        run_start();
        chk("t1_seq_busy_after_start", {31'd0, seq_busy}, 32'd1);
        chk("t1_no_strobe_on_start_edge", {31'd0, ctrl.cmd_valid}, 32'd0);
        tick();
        chk("t1_first_strobe_latency", {31'd0, ctrl.cmd_valid}, 32'd1);
        wait_seq_done(100, "t1");
        chk("t1_cmd_count", {27'd0, cmd_count}, 32'd4);
        chk("t1_strobes", strobes, 4);
        chk("t1_sb_empty", sb.size(), 0);
        chk("t1_seq_busy_end", {31'd0, seq_busy}, 32'd0);

        // Full script of 5s: implicit write after the last entry
        for (int i = 0; i < DEPTH; i++) prog(i, 5);
        for (int i = 0; i < DEPTH; i++) sb.push_back(3'd5);
        sb.push_back(3'd0);
        run_start();
        wait_seq_done(400, "t2");
        chk("t2_cmd_count", {27'd0, cmd_count}, 32'd17);
        chk("t2_strobes", strobes, 17);
        chk("t2_sb_empty", sb.size(), 0);

        // Controller never raises busy: each strobe spaced by the ack timeout
        prog(0, 2); prog(1, 4); prog(2, 0);
        ctrl_mode = 1;
        push3(2, 4, 0);
        run_start();
        n = 0;
        while (strobes < 3 && n < 100) begin
            tick();
            n++;
        end
        chk("t3_strobes", strobes, 3);
        repeat (ACK_TO + 3) tick();
        chk("t3_waits_for_done", {31'd0, seq_done}, 32'd0);
        chk("t3_still_busy", {31'd0, seq_busy}, 32'd1);
        ctrl.done = 1'b1;
        tick();
        chk("t3_seq_done", {31'd0, seq_done}, 32'd1);
        chk("t3_cmd_count", {27'd0, cmd_count}, 32'd3);
        ctrl_mode = 0;

        // start and prog_we during a run are ignored
        push3(2, 4, 0);
        run_start();
        tick();
        start     = 1'b1;
        prog_we   = 1'b1;
        prog_addr = '0;
        prog_data = 3'd7;
        tick();
        start     = 1'b0;
        prog_we   = 1'b0;
        wait_seq_done(100, "t4");
        chk("t4_cmd_count", {27'd0, cmd_count}, 32'd3);
        chk("t4_strobes", strobes, 3);
        chk("t4_sb_empty", sb.size(), 0);
        push3(2, 4, 0);
        run_start();
        wait_seq_done(100, "t4_rerun");
        chk("t4_rerun_strobes", strobes, 3);
        chk("t4_rerun_sb_empty", sb.size(), 0);

        // Reset while waiting for ack; script retained
        push3(2, 4, 0);
        run_start();
        n = 0;
        while (!strobe_now && n < 20) begin
            tick();
            n++;
        end
        chk("t5_reached_wait_ack", {31'd0, strobe_now}, 32'd1);
        reset = 1'b1;
        tick();
        chk("t5_cmd_valid", {31'd0, ctrl.cmd_valid}, 32'd0);
        chk("t5_seq_busy", {31'd0, seq_busy}, 32'd0);
        chk("t5_cmd_count", {27'd0, cmd_count}, 32'd0);
        reset = 1'b0;
        sb.delete();
        ctrl.busy      = 1'b0;
        pend           = 0;
        bcnt           = 0;
        last_was_write = 0;
        repeat (3) tick();
        chk("t5_no_strobe_after_reset", {31'd0, ctrl.cmd_valid}, 32'd0);
        push3(2, 4, 0);
        run_start();
        wait_seq_done(100, "t5_replay");
        chk("t5_replay_strobes", strobes, 3);
        chk("t5_replay_count", {27'd0, cmd_count}, 32'd3);

        // busy held high after start: strobe waits for busy low
        ctrl_mode = 2;
        ctrl.busy = 1'b1;
        push3(2, 4, 0);
        run_start();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t6_no_strobe_while_busy", {31'd0, ctrl.cmd_valid}, 32'd0);
        end
        ctrl.busy = 1'b0;
        ctrl_mode = 0;
        tick();
        chk("t6_strobe_after_busy_low", {31'd0, ctrl.cmd_valid}, 32'd1);
        wait_seq_done(100, "t6");
        chk("t6_cmd_count", {27'd0, cmd_count}, 32'd3);
        chk("t6_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
